// File: rtl/midori_sbox_scheduler.sv
// Round scheduler for a shared, pipelined Midori64 S-box datapath.
// Each round issues the 16 state nibbles one per cycle into the S-box
// pipeline. It then waits for the pipeline to drain, fires the linear layer
// once, and moves on to the next round until the encryption completes.
module midori_sbox_scheduler #(
    parameter int NIBBLES = 16,
    parameter int STAGES  = 2,
    parameter int ROUNDS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              nib_valid_in,
    output logic [3:0]        nib_sel_in,
    output logic [STAGES-1:0] stage_en,
    output logic              nib_wr_en,
    output logic [3:0]        nib_sel_out,
    output logic              lin_en,
    output logic [3:0]        round,
    output logic              last_round
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SBOX,
        S_DRAIN,
        S_LIN,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_NIB   = 4'(NIBBLES - 1);
    localparam logic [1:0] LAST_DRAIN = 2'(STAGES - 1);
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    state_t      state_reg;
    logic [3:0]  issue_cnt_reg;
    logic [1:0]  drain_cnt_reg;

    // Pipeline tracking: valid bits and nibble indices ride alongside the data.
    logic [STAGES-1:0] v_reg;
    logic [STAGES-1:0] v_next;
    logic [3:0]        idx_reg  [STAGES];
    logic [3:0]        idx_next [STAGES];

    // Control FSM; every output is registered so the datapath sees clean enables.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            issue_cnt_reg <= 4'd0;
            drain_cnt_reg <= 2'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            nib_valid_in  <= 1'b0;
            nib_sel_in    <= 4'd0;
            lin_en        <= 1'b0;
            round         <= 4'd0;
            last_round    <= 1'b0;
        end else begin
            done   <= 1'b0;
            lin_en <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg     <= S_SBOX;
                        round         <= 4'd0;
                        issue_cnt_reg <= 4'd0;
                        busy          <= 1'b1;
                        nib_valid_in  <= 1'b1;
                        nib_sel_in    <= 4'd0;
                        last_round    <= (LAST_ROUND == 4'd0);
                    end
                end
                S_SBOX: begin
                    if (issue_cnt_reg == LAST_NIB) begin
                        state_reg     <= S_DRAIN;
                        drain_cnt_reg <= 2'd0;
                        nib_valid_in  <= 1'b0;
                        nib_sel_in    <= 4'd0;
                    end else begin
                        issue_cnt_reg <= issue_cnt_reg + 4'd1;
                        nib_sel_in    <= issue_cnt_reg + 4'd1;
                    end
                end
                S_DRAIN: begin
                    // The final drain cycle carries the last write-back, so the
                    // linear layer only ever sees a fully substituted state.
                    if (drain_cnt_reg == LAST_DRAIN) begin
                        state_reg <= S_LIN;
                        lin_en    <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 2'd1;
                    end
                end
                S_LIN: begin
                    if (round == LAST_ROUND) begin
                        state_reg  <= S_DONE;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        last_round <= 1'b0;
                    end else begin
                        state_reg     <= S_SBOX;
                        round         <= round + 4'd1;
                        last_round    <= ((round + 4'd1) == LAST_ROUND);
                        issue_cnt_reg <= 4'd0;
                        nib_valid_in  <= 1'b1;
                        nib_sel_in    <= 4'd0;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Shift inputs: stage 0 takes the issued nibble, later stages take their predecessor.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign v_next[gi]   = nib_valid_in;
                assign idx_next[gi] = nib_sel_in;
            end else begin : g_body
                assign v_next[gi]   = v_reg[gi-1];
                assign idx_next[gi] = idx_reg[gi-1];
            end
            assign stage_en[gi] = v_next[gi];
        end
    endgenerate

    // Advance the valid/index shadow pipeline; reset discards in-flight nibbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_reg <= '0;
            for (int i = 0; i < STAGES; i++) begin
                idx_reg[i] <= 4'd0;
            end
        end else begin
            v_reg <= v_next;
            for (int i = 0; i < STAGES; i++) begin
                idx_reg[i] <= idx_next[i];
            end
        end
    end

    assign nib_wr_en   = v_reg[STAGES-1];
    assign nib_sel_out = idx_reg[STAGES-1];

endmodule
